// File: rtl/scan_ctrl_pkg.sv
// Shared types and limits for the scan chain controller.
// State encoding is fixed at two bits.
package scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int MIN_DEPTH = 2;
  localparam int MAX_DEPTH = 256;

endpackage

// File: rtl/scan_shreg.sv
// Parallel-load / serial-in right shift register.
// Holds its value when neither load nor shift is asserted.
module scan_shreg #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [DEPTH-1:0] load_data,
  input  logic             serial_in,
  output logic [DEPTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {serial_in, q[DEPTH-1:1]};
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shifts a load word in while unloading the chain.
// Define SCAN_CAPTURE_EN to add the one-cycle functional capture state.
import scan_ctrl_pkg::*;

module scan_chain_ctrl #(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DEPTH-1:0] in_data,
  output logic             scan_en,
  output logic             scan_in,
  input  logic             scan_out,
  output logic             scan_capture,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DEPTH-1:0] out_data,
  output logic             busy
);

  if (DEPTH < MIN_DEPTH || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("scan_chain_ctrl: DEPTH out of range");
  end

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [DEPTH-1:0] shreg_q;
  logic             load;
  logic             last;

  assign load = in_valid & in_ready;
  assign last = (cnt_q == CNT_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) state_d = SHIFT;
      end
      SHIFT: begin
`ifdef SCAN_CAPTURE_EN
        if (last) state_d = CAPTURE;
`else
        if (last) state_d = DONE;
`endif
      end
      CAPTURE: state_d = DONE;
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    scan_en   = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      SHIFT:   scan_en   = 1'b1;
      CAPTURE: scan_en   = 1'b0;
      DONE:    out_valid = 1'b1;
      default: busy      = 1'b1;
    endcase
  end

`ifdef SCAN_CAPTURE_EN
  assign scan_capture = (state_q == CAPTURE);
`else
  assign scan_capture = 1'b0;
`endif

  // Counter saturates on the final shift so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (scan_en && !last) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  scan_shreg #(
    .DEPTH(DEPTH)
  ) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift    (scan_en),
    .load_data(in_data),
    .serial_in(scan_out),
    .q        (shreg_q)
  );

  assign scan_in  = scan_en & shreg_q[0];
  assign out_data = shreg_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with an 8-flop chain model.
// Build with SCAN_CAPTURE_EN to exercise the capture state.
module tb_scan_chain_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       scan_en;
  logic       scan_in;
  logic       scan_out;
  logic       scan_capture;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  logic [7:0] chain = 8'h00;
  logic       cap_load = 1'b0;
  logic [7:0] cap_val = 8'h00;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scan_chain_ctrl #(
    .DEPTH(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .scan_en     (scan_en),
    .scan_in     (scan_in),
    .scan_out    (scan_out),
    .scan_capture(scan_capture),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy)
  );

  // chain[0] is the head, chain[7] the tail
  assign scan_out = chain[7];

  always @(posedge clk) begin
    if (scan_capture && cap_load) begin
      chain <= cap_val;
    end else if (scan_en) begin
      chain <= {chain[6:0], scan_in};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [7:0] w, input logic [7:0] exp,
                    input int hold, input bit spam);
    chk("idle_rdy", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = w;
    step();
    if (spam) in_data = 8'hFF;
    else in_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("sh_en", 32'(scan_en), 32'd1);
      chk("sh_in", 32'(scan_in), 32'(w[i-1]));
      chk("sh_rdy", 32'(in_ready), 32'd0);
      chk("sh_ov", 32'(out_valid), 32'd0);
      chk("sh_cap", 32'(scan_capture), 32'd0);
      step();
    end
`ifdef SCAN_CAPTURE_EN
    chk("cap_pulse", 32'(scan_capture), 32'd1);
    chk("cap_en", 32'(scan_en), 32'd0);
    chk("cap_ov", 32'(out_valid), 32'd0);
    step();
`endif
    in_valid = 1'b0;
    for (int h = 0; h < hold; h++) begin
      chk("hold_ov", 32'(out_valid), 32'd1);
      chk("hold_od", 32'(out_data), 32'(exp));
      chk("hold_rdy", 32'(in_ready), 32'd0);
      chk("hold_en", 32'(scan_en), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_cap", 32'(scan_capture), 32'd0);
      step();
    end
    chk("done_ov", 32'(out_valid), 32'd1);
    chk("done_od", 32'(out_data), 32'(exp));
    chk("done_en", 32'(scan_en), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("ret_ov", 32'(out_valid), 32'd0);
    chk("ret_rdy", 32'(in_ready), 32'd1);
    chk("ret_busy", 32'(busy), 32'd0);
    chk("ret_en", 32'(scan_en), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_en", 32'(scan_en), 32'd0);
    chk("rst_in", 32'(scan_in), 32'd0);
    chk("rst_cap", 32'(scan_capture), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_od", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();

    op(8'hA5, 8'h00, 0, 1'b0);
    chk("chain_a5", 32'(chain), 32'hA5);
    op(8'h3C, 8'hA5, 0, 1'b0);
    op(8'h00, 8'h3C, 5, 1'b0);
    op(8'hC3, 8'h00, 0, 1'b1);
    chk("chain_spam", 32'(chain), 32'hC3);

    // reset sampled on the 3rd shift edge: exactly 3 bits enter the chain
    in_valid = 1'b1;
    in_data  = 8'h96;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    chk("mid_en", 32'(scan_en), 32'd0);
    chk("mid_ov", 32'(out_valid), 32'd0);
    chk("mid_rdy", 32'(in_ready), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_chain", 32'(chain), 32'h1B);
    reset = 1'b0;
    step();
    chk("mid_chain2", 32'(chain), 32'h1B);

    // 0x1B unloads tail-first, i.e. bit-reversed
    op(8'h24, 8'hD8, 0, 1'b0);

`ifdef SCAN_CAPTURE_EN
    cap_load = 1'b1;
    cap_val  = 8'h5A;
    op(8'h11, 8'h24, 0, 1'b0);
    cap_load = 1'b0;
    chk("chain_cap", 32'(chain), 32'h5A);
    op(8'h00, 8'h5A, 0, 1'b0);
`else
    op(8'h11, 8'h24, 0, 1'b0);
    op(8'h00, 8'h11, 0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
